// File: rtl/memory_unit_if.sv
// rtl/memory_unit_if.sv - request/complete bus between the datapath and memory_unit
//
// Signals:
//   Read, Write  request strobes from the control unit
//   MAR_Data     word address from the MAR
//   MDR_Data     write data from the MDR
//   MData_Out    last completed read word, feeds the MDR memory input
//   Busy         unit is not idle; new requests are ignored
//   Done         one-cycle completion pulse
//   Fault        one-cycle out-of-range pulse
// Modports: master = datapath/control side, slave = memory side.

interface memory_unit_if;
    logic        Read;
    logic        Write;
    logic [31:0] MAR_Data;
    logic [31:0] MDR_Data;
    logic [31:0] MData_Out;
    logic        Busy;
    logic        Done;
    logic        Fault;

    modport master (
        output Read, Write, MAR_Data, MDR_Data,
        input  MData_Out, Busy, Done, Fault
    );

    modport slave (
        input  Read, Write, MAR_Data, MDR_Data,
        output MData_Out, Busy, Done, Fault
    );
endinterface

// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - word-addressed 32-bit memory with fixed wait states and Done handshake
//
// Parameters:
//   ADDR_WIDTH   word-address width, depth = 2**ADDR_WIDTH words
//   WAIT_CYCLES  extra access cycles, 0..15
// Ports:
//   Clock        rising-edge clock
//   Clear        asynchronous active-low reset
//   bus          memory_unit_if.slave (Read/Write/MAR_Data/MDR_Data in,
//                MData_Out/Busy/Done/Fault out)
// Optional feature macro: MEM_RANGE_CHECK_EN
//   defined   - nonzero MAR_Data[31:ADDR_WIDTH] completes with Fault instead of Done,
//               with no array write and no MData_Out update
//   undefined - upper address bits are ignored and Fault stays 0

module memory_unit #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic         Clock,
    input  logic         Clear,
    memory_unit_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

    state_t                state;
    logic [3:0]            count;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           mdata_q;
    logic                  op_write;
    logic                  op_fault;
    logic                  busy_q;
    logic                  done_q;
    logic                  fault_q;
    logic                  req_oor;
    logic                  mem_we;
    logic [31:0]           mem [DEPTH];

`ifdef MEM_RANGE_CHECK_EN
    assign req_oor = |bus.MAR_Data[31:ADDR_WIDTH];
`else
    assign req_oor = 1'b0;
`endif

    // Write enable is derived from registered state, so an asynchronous
    // Clear forces IDLE and an in-flight write can never reach the array.
    assign mem_we = (state == ST_ACCESS) && (count == 4'd0) && op_write && !op_fault;

    // The array has no reset: contents survive Clear.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state    <= ST_IDLE;
            count    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            mdata_q  <= 32'd0;
            op_write <= 1'b0;
            op_fault <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.Read || bus.Write) begin
                        addr_q   <= bus.MAR_Data[ADDR_WIDTH-1:0];
                        wdata_q  <= bus.MDR_Data;
                        // Write takes priority when both strobes are high.
                        op_write <= bus.Write;
                        op_fault <= req_oor;
                        count    <= 4'(WAIT_CYCLES);
                        busy_q   <= 1'b1;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        if (!op_write && !op_fault) begin
                            mdata_q <= mem[addr_q];
                        end
                        done_q  <= !op_fault;
                        fault_q <= op_fault;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.MData_Out = mdata_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Fault     = fault_q;
endmodule

// File: tb/tb_memory_unit.sv
// tb/tb_memory_unit.sv - directed self-checking bench for memory_unit (WAIT_CYCLES 2, 0, 15)

module tb_memory_unit;
    logic        clk;
    logic        clear;
    logic        read_r;
    logic        write_r;
    logic [31:0] mar_r;
    logic [31:0] mdr_r;

    int errors = 0;
    int checks = 0;

    memory_unit_if bus0();
    memory_unit_if bus1();
    memory_unit_if bus2();

    assign bus0.Read = read_r;  assign bus0.Write = write_r;
    assign bus0.MAR_Data = mar_r; assign bus0.MDR_Data = mdr_r;
    assign bus1.Read = read_r;  assign bus1.Write = write_r;
    assign bus1.MAR_Data = mar_r; assign bus1.MDR_Data = mdr_r;
    assign bus2.Read = read_r;  assign bus2.Write = write_r;
    assign bus2.MAR_Data = mar_r; assign bus2.MDR_Data = mdr_r;

    memory_unit #(.ADDR_WIDTH(9), .WAIT_CYCLES(2))  u_w2  (.Clock(clk), .Clear(clear), .bus(bus0.slave));
    memory_unit #(.ADDR_WIDTH(9), .WAIT_CYCLES(0))  u_w0  (.Clock(clk), .Clear(clear), .bus(bus1.slave));
    memory_unit #(.ADDR_WIDTH(9), .WAIT_CYCLES(15)) u_w15 (.Clock(clk), .Clear(clear), .bus(bus2.slave));

    wire [2:0]  done_v  = {bus2.Done,  bus1.Done,  bus0.Done};
    wire [2:0]  fault_v = {bus2.Fault, bus1.Fault, bus0.Fault};
    wire [2:0]  busy_v  = {bus2.Busy,  bus1.Busy,  bus0.Busy};
    wire [31:0] mdata_v [3];
    assign mdata_v[0] = bus0.MData_Out;
    assign mdata_v[1] = bus1.MData_Out;
    assign mdata_v[2] = bus2.MData_Out;

    // Per-instance observations of the last request.
    int          r_done_edge  [3];
    int          r_fault_edge [3];
    int          r_n_done     [3];
    int          r_n_fault    [3];
    int          r_n_busy     [3];
    logic [31:0] r_rdata      [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request (E0 = edge 0) and watch 20 further edges on all units.
    // With inject set, a Write to 0x010 is pulsed while the units are busy.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input bit inject);
        for (int i = 0; i < 3; i++) begin
            r_done_edge[i] = -1; r_fault_edge[i] = -1;
            r_n_done[i] = 0; r_n_fault[i] = 0; r_n_busy[i] = 0; r_rdata[i] = 32'h0;
        end
        @(negedge clk);
        read_r = rd; write_r = wr; mar_r = addr; mdr_r = data;
        @(posedge clk); #1;
        read_r = 1'b0; write_r = 1'b0; mar_r = ~addr; mdr_r = ~data;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            for (int i = 0; i < 3; i++) begin
                if (busy_v[i]) r_n_busy[i]++;
                if (done_v[i]) begin
                    r_n_done[i]++;
                    if (r_done_edge[i] < 0) begin
                        r_done_edge[i] = k;
                        r_rdata[i] = mdata_v[i];
                    end
                end
                if (fault_v[i]) begin
                    r_n_fault[i]++;
                    if (r_fault_edge[i] < 0) r_fault_edge[i] = k;
                end
            end
            if (inject && k == 1) begin
                write_r = 1'b1; mar_r = 32'h0000_0010; mdr_r = 32'hBAD0_BAD0;
            end
            if (inject && k == 2) write_r = 1'b0;
        end
    endtask

    task automatic test_reset;
        clear = 1'b0; read_r = 1'b0; write_r = 1'b0; mar_r = 32'h0; mdr_r = 32'h0;
        #2;
        checks++; if (bus0.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus0.Busy); end
        checks++; if (bus0.Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus0.Done); end
        checks++; if (bus0.Fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", bus0.Fault); end
        checks++; if (bus0.MData_Out !== 32'h0) begin errors++; $display("FAIL reset_mdata got=%h exp=0", bus0.MData_Out); end
        repeat (2) @(negedge clk);
        clear = 1'b1;
    endtask

    task automatic test_write_read;
        run_req(1'b0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 1'b0);
        checks++; if (r_done_edge[0] !== 3) begin errors++; $display("FAIL wr_done_edge got=%0d exp=3", r_done_edge[0]); end
        checks++; if (r_n_done[0] !== 1) begin errors++; $display("FAIL wr_done_count got=%0d exp=1", r_n_done[0]); end
        checks++; if (r_n_busy[0] !== 4) begin errors++; $display("FAIL wr_busy_cycles got=%0d exp=4", r_n_busy[0]); end
        checks++; if (r_n_fault[0] !== 0) begin errors++; $display("FAIL wr_fault_count got=%0d exp=0", r_n_fault[0]); end
        run_req(1'b1, 1'b0, 32'h0000_0005, 32'h0, 1'b0);
        checks++; if (r_done_edge[0] !== 3) begin errors++; $display("FAIL rd_done_edge got=%0d exp=3", r_done_edge[0]); end
        checks++; if (r_rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data_at_done got=%h exp=deadbeef", r_rdata[0]); end
        checks++; if (r_n_busy[0] !== 4) begin errors++; $display("FAIL rd_busy_cycles got=%0d exp=4", r_n_busy[0]); end
        checks++; if (bus0.MData_Out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data_held got=%h exp=deadbeef", bus0.MData_Out); end
    endtask

    task automatic test_latency;
        run_req(1'b0, 1'b1, 32'h0000_0007, 32'h0000_0707, 1'b0);
        checks++; if (r_done_edge[1] !== 1) begin errors++; $display("FAIL w0_done_edge got=%0d exp=1", r_done_edge[1]); end
        checks++; if (r_n_done[1] !== 1) begin errors++; $display("FAIL w0_done_count got=%0d exp=1", r_n_done[1]); end
        checks++; if (r_n_busy[1] !== 2) begin errors++; $display("FAIL w0_busy_cycles got=%0d exp=2", r_n_busy[1]); end
        checks++; if (r_done_edge[2] !== 16) begin errors++; $display("FAIL w15_done_edge got=%0d exp=16", r_done_edge[2]); end
        checks++; if (r_n_done[2] !== 1) begin errors++; $display("FAIL w15_done_count got=%0d exp=1", r_n_done[2]); end
        checks++; if (r_n_busy[2] !== 17) begin errors++; $display("FAIL w15_busy_cycles got=%0d exp=17", r_n_busy[2]); end
    endtask

    task automatic test_busy_reject;
        run_req(1'b0, 1'b1, 32'h0000_0001, 32'h1111_1111, 1'b0);
        run_req(1'b0, 1'b1, 32'h0000_0010, 32'h2222_2222, 1'b0);
        run_req(1'b1, 1'b0, 32'h0000_0001, 32'h0, 1'b1);
        checks++; if (r_n_done[0] !== 1) begin errors++; $display("FAIL busy_done_count got=%0d exp=1", r_n_done[0]); end
        checks++; if (r_rdata[0] !== 32'h1111_1111) begin errors++; $display("FAIL busy_read_data got=%h exp=11111111", r_rdata[0]); end
        run_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        checks++; if (r_rdata[0] !== 32'h2222_2222) begin errors++; $display("FAIL busy_addr10_kept got=%h exp=22222222", r_rdata[0]); end
    endtask

    task automatic test_read_write_collision;
        run_req(1'b1, 1'b0, 32'h0000_0005, 32'h0, 1'b0);
        run_req(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0);
        checks++; if (r_n_done[0] !== 1) begin errors++; $display("FAIL rw_done_count got=%0d exp=1", r_n_done[0]); end
        checks++; if (bus0.MData_Out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rw_mdata_kept got=%h exp=deadbeef", bus0.MData_Out); end
        run_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
        checks++; if (r_rdata[0] !== 32'h1234_5678) begin errors++; $display("FAIL rw_array_write got=%h exp=12345678", r_rdata[0]); end
    endtask

    task automatic test_reset_mid_access;
        run_req(1'b0, 1'b1, 32'h0000_0030, 32'h0000_0001, 1'b0);
        run_req(1'b1, 1'b0, 32'h0000_0030, 32'h0, 1'b0);
        @(negedge clk);
        read_r = 1'b0; write_r = 1'b1; mar_r = 32'h0000_0030; mdr_r = 32'hAAAA_5555;
        @(posedge clk); #1;
        write_r = 1'b0;
        @(posedge clk); #3;
        checks++; if (bus0.Busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got=%b exp=1", bus0.Busy); end
        clear = 1'b0;
        #1;
        checks++; if (bus0.Busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got=%b exp=0", bus0.Busy); end
        checks++; if (bus0.MData_Out !== 32'h0) begin errors++; $display("FAIL rst_async_mdata got=%h exp=0", bus0.MData_Out); end
        checks++; if (bus0.Done !== 1'b0) begin errors++; $display("FAIL rst_async_done got=%b exp=0", bus0.Done); end
        repeat (2) @(negedge clk);
        clear = 1'b1;
        run_req(1'b1, 1'b0, 32'h0000_0030, 32'h0, 1'b0);
        checks++; if (r_rdata[0] !== 32'h0000_0001) begin errors++; $display("FAIL rst_write_abandoned got=%h exp=1", r_rdata[0]); end
    endtask

    task automatic test_range;
        run_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        run_req(1'b0, 1'b1, 32'h0000_0205, 32'hCAFE_F00D, 1'b0);
`ifdef MEM_RANGE_CHECK_EN
        checks++; if (r_n_fault[0] !== 1) begin errors++; $display("FAIL oor_fault_count got=%0d exp=1", r_n_fault[0]); end
        checks++; if (r_fault_edge[0] !== 3) begin errors++; $display("FAIL oor_fault_edge got=%0d exp=3", r_fault_edge[0]); end
        checks++; if (r_n_done[0] !== 0) begin errors++; $display("FAIL oor_done_count got=%0d exp=0", r_n_done[0]); end
        run_req(1'b1, 1'b0, 32'h0000_0205, 32'h0, 1'b0);
        checks++; if (bus0.MData_Out !== 32'h2222_2222) begin errors++; $display("FAIL oor_read_mdata got=%h exp=22222222", bus0.MData_Out); end
        run_req(1'b1, 1'b0, 32'h0000_0005, 32'h0, 1'b0);
        checks++; if (r_rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oor_word5 got=%h exp=deadbeef", r_rdata[0]); end
`else
        checks++; if (r_n_done[0] !== 1) begin errors++; $display("FAIL alias_done_count got=%0d exp=1", r_n_done[0]); end
        checks++; if (r_n_fault[0] !== 0) begin errors++; $display("FAIL alias_fault_count got=%0d exp=0", r_n_fault[0]); end
        run_req(1'b1, 1'b0, 32'h0000_0005, 32'h0, 1'b0);
        checks++; if (r_rdata[0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL alias_word5 got=%h exp=cafef00d", r_rdata[0]); end
`endif
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_latency;
        test_busy_reject;
        test_read_write_collision;
        test_reset_mid_access;
        test_range;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/memory_unit.md
# memory_unit

Word-addressed 32-bit main memory with a request/complete handshake. It sits directly downstream of the single-bus datapath. It takes its address from the MAR contents and its write data from the MDR contents. It returns read data on the line that feeds the MDR's memory input (`MData_In`). A fixed, parameterised wait-state count models slow memory, so the control unit must wait for `Done` before loading the MDR.

## Interface
Parameters:
- `ADDR_WIDTH`, default 9: word-address width; depth is 2**ADDR_WIDTH words.
- `WAIT_CYCLES`, default 2: extra access cycles, legal range 0..15.

Ports:
- `Clock`  input  1  system clock; all state changes on the rising edge.
- `Clear`  input  1  reset, asynchronous and active-low (0 = reset).
- `Read`  input  1  read request; sampled only in IDLE.
- `Write`  input  1  write request; sampled only in IDLE.
- `MAR_Data`  input  32  address from MAR; bits [ADDR_WIDTH-1:0] select the word.
- `MDR_Data`  input  32  write data from MDR.
- `MData_Out`  output  32  read data to the datapath `MData_In`; holds the last completed read.
- `Busy`  output  1  high in every state except IDLE.
- `Done`  output  1  one-cycle completion pulse.
- `Fault`  output  1  one-cycle out-of-range pulse (see Configuration).

## Operation
- State machine: IDLE, ACCESS, DONE. All outputs are registered.
- **IDLE**
  - On an edge with `Read` or `Write` high: latch the address, the write data and the operation; load the counter with WAIT_CYCLES; go to ACCESS.
  - If `Read` and `Write` are both high: Write wins, and no read is performed.
- **ACCESS**
  - Counter is non-zero: decrement it and stay in ACCESS.
  - Counter is 0:
    - Write: store the latched data in the array.
    - Read: load the array word into `MData_Out`.
    - Then assert `Done` (or `Fault`) and go to DONE.
- **DONE**: on the next edge, clear `Done`/`Fault` and go to IDLE.
- Requests seen while `Busy` is high are ignored, not queued.
- `MData_Out` changes only on read completion or reset. Writes and faults leave it unchanged.
- Addresses wrap modulo the depth.
- Reset (`Clear` low), at any time including mid-access:
  - `MData_Out` = 0, `Done` = 0, `Fault` = 0, `Busy` = 0.
  - State returns to IDLE and the counter to 0.
  - An in-flight write is abandoned and the array is not modified.
  - Array contents are not cleared by reset.

## Timing
- Request sampled at edge E0 puts the unit in ACCESS after E0.
- The array access happens at edge E0+WAIT_CYCLES+1; `Done` is high for the cycle that follows.
- IDLE is re-entered after edge E0+WAIT_CYCLES+2.
- Earliest next request is sampled at E0+WAIT_CYCLES+3.
- With WAIT_CYCLES=0, one access is 3 cycles from request to the next acceptable request.
- Read data is valid in `MData_Out` in the same cycle `Done` is high. The control unit asserts the MDR `Read`/`MDR_In` during that cycle.
- `Busy` rises after E0 and falls after E0+WAIT_CYCLES+2.
- Requesters hold `MAR_Data`/`MDR_Data` only through E0, because both are latched at E0.

## Configuration
- Macro: `MEM_RANGE_CHECK_EN`.
- Defined:
  - A request with any of `MAR_Data[31:ADDR_WIDTH]` non-zero completes at the normal time with `Fault`=1 and `Done`=0.
  - A faulted write does not modify the array.
  - A faulted read leaves `MData_Out` unchanged.
- Undefined:
  - Upper address bits are ignored, so addresses alias into the array.
  - `Fault` is tied to 0.

## Test plan
1. Write-then-read (WAIT_CYCLES=2).
   - Write 0xDEADBEEF to address 0x005.
   - `Done` is high exactly 3 edges after the request edge.
   - Read 0x005 returns `MData_Out`=0xDEADBEEF with `Done`.
   - `Busy` is high for 4 cycles per access.
2. Latency sweep: WAIT_CYCLES=0 and 15 give `Done` at request edge +1 and +16 respectively, with no early pulse.
3. Busy rejection.
   - Pulse `Write` to address 0x010 while a read of address 0x001 is in ACCESS.
   - Address 0x010 is unchanged afterwards.
   - Only one `Done` pulse occurs.
4. Simultaneous `Read`+`Write` to address 0x020 with data 0x12345678.
   - The array holds 0x12345678.
   - `MData_Out` keeps its prior value.
5. Reset mid-access.
   - Assert `Clear` low during ACCESS of a write of 0xAAAA5555 to address 0x030, which previously held 0x1.
   - Outputs go to 0 asynchronously.
   - A later read of 0x030 returns 0x1.
6. Out-of-range address 0x00000205 (ADDR_WIDTH=9).
   - With the macro: `Fault` pulse, no `Done`, and word 0x005 is unchanged by a write.
   - Without the macro: a write lands at word 0x005 with `Done`.
